// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU and load results into one register-file write port through a small pending-write FIFO.
// Latency: a result accepted into an empty queue is strobed on the write port on the following edge (2 edges input to strobe).
// Backpressure: ld_ready drops only when the queue is full; alu_ready also drops whenever a load is offered, because loads take priority.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic [4:0]               rd,
  output logic                     enable,
  output logic [31:0]              data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic [31:0]              rs1_fwd,
  output logic [31:0]              rs2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic        full;
  logic        ld_acc;
  logic        alu_acc;
  logic        push;
  logic        pop;
  logic [4:0]  in_rd;
  logic [31:0] in_data;

  // Ready depends only on occupancy, never on the same-cycle pop, so it cannot form a loop with the drain.
  always_comb begin
    full      = (count == CW'(DEPTH));
    ld_ready  = !full;
    alu_ready = !full && !ld_valid;
    ld_acc    = ld_valid && ld_ready;
    alu_acc   = alu_valid && alu_ready;
    in_rd     = ld_acc ? ld_rd : alu_rd;
    in_data   = ld_acc ? ld_data : alu_data;
    // Writes to x0 are consumed but dropped: the register file ignores them anyway.
    push      = (ld_acc || alu_acc) && (in_rd != 5'd0);
    pop       = (count != '0);
  end

  // Queue control, occupancy and the registered write port; the head entry drains every cycle it exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      enable  <= 1'b0;
      rd      <= 5'd0;
      data    <= 32'd0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
        rd            <= ent_rd[head];
        data          <= ent_data[head];
        enable        <= 1'b1;
      end else begin
        enable        <= 1'b0;
      end
      // Push never lands on the head slot being popped: a push into a non-empty queue implies not full.
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; the valid flags gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail]   <= in_rd;
      ent_data[tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; the output register is older than any queued entry.
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic          hit;
    logic [31:0]   fwd;
    logic [PW-1:0] idx;
    hit = 1'b0;
    fwd = 32'd0;
    if (enable && (rd == rs)) begin
      hit = 1'b1;
      fwd = data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && ent_vld[idx] && (ent_rd[idx] == rs)) begin
        hit = 1'b1;
        fwd = ent_data[idx];
      end
    end
    if (rs == 5'd0) begin
      hit = 1'b0;
      fwd = 32'd0;
    end
    return {hit, fwd};
  endfunction

  // Bypass both read ports from current state only; results arriving this cycle are not yet visible.
  always_comb begin
    {rs1_hit, rs1_fwd} = lookup(rs1);
    {rs2_hit, rs2_fwd} = lookup(rs2);
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vectors with a scoreboard of expected register-file writes.
// Stimulus pushes the expected write when a result is accepted; a monitor pops and compares on every enable strobe.
// Also checks reset state, ready priority, x0 dropping, bypass values and reset mid-drain.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rd;
  logic        enable;
  logic [31:0] data;
  logic [4:0]  rs1, rs2;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  logic [36:0] sb [$];

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rd(rd), .enable(enable), .data(data),
    .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one result, wait (bounded) for ready, record the expected write, then drop valid after the accepting edge.
  task automatic send(input bit is_ld, input logic [4:0] r, input logic [31:0] d);
    bit ok = 1'b0;
    if (is_ld) begin ld_valid = 1'b1; ld_rd = r; ld_data = d; end
    else       begin alu_valid = 1'b1; alu_rd = r; alu_data = d; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_ld ? ld_ready : alu_ready) begin ok = 1'b1; break; end
    end
    check("ready_timeout", {31'd0, ok}, 32'd1);
    if (ok && r != 5'd0) sb.push_back({r, d});
    @(posedge clk);
    #1;
    if (is_ld) ld_valid = 1'b0; else alu_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected write; occupancy never exceeds DEPTH.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (enable === 1'b1) begin
          if (sb.size() == 0) begin
            check("wr_unexpected", {31'd0, enable}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("wr_rd",   {27'd0, rd}, {27'd0, e[36:32]});
            check("wr_data", data, e[31:0]);
          end
        end
        check("count_max", 32'(count > DEPTH), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_count",  32'(count), 32'd0);
    check("rst_rd",     {27'd0, rd}, 32'd0);
    check("rst_data",   data, 32'd0);
    check("rst_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check("rst_ld_rdy",  {31'd0, ld_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single ALU result: strobe two edges after offer, exactly one cycle.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    check("single_rdy", {31'd0, alu_ready}, 32'd1);
    sb.push_back({5'd5, 32'hDEADBEEF});
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    check("single_en_n1", {31'd0, enable}, 32'd0);
    check("single_cnt_n1", 32'(count), 32'd1);
    @(negedge clk);
    check("single_en_n2", {31'd0, enable}, 32'd1);
    check("single_cnt_n2", 32'(count), 32'd0);
    @(negedge clk);
    check("single_en_n3", {31'd0, enable}, 32'd0);

    // Load and ALU together: load first, ALU held off one cycle.
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    @(negedge clk);
    check("prio_ld_rdy",  {31'd0, ld_ready},  32'd1);
    check("prio_alu_rdy", {31'd0, alu_ready}, 32'd0);
    sb.push_back({5'd3, 32'h11});
    @(posedge clk); #1 ld_valid = 1'b0;
    @(negedge clk);
    check("prio_alu_rdy2", {31'd0, alu_ready}, 32'd1);
    sb.push_back({5'd4, 32'h22});
    @(posedge clk); #1 alu_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Six back-to-back ALU results: all emitted in order.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(1'b0, 5'(20 + i), 32'h100 + 32'(i));
    repeat (5) @(negedge clk);
    check("burst_drained", 32'(count), 32'd0);

    // Bypass: two writes to x7; youngest wins, output register also searched.
    @(posedge clk); #1;
    rs1 = 5'd7; rs2 = 5'd0;
    send(1'b0, 5'd7, 32'h1);
    send(1'b0, 5'd7, 32'h2);
    @(negedge clk);
    check("byp_hit_q",  {31'd0, rs1_hit}, 32'd1);
    check("byp_fwd_q",  rs1_fwd, 32'h2);
    check("byp_hit_x0", {31'd0, rs2_hit}, 32'd0);
    check("byp_fwd_x0", rs2_fwd, 32'd0);
    @(negedge clk);
    check("byp_hit_out", {31'd0, rs1_hit}, 32'd1);
    check("byp_fwd_out", rs1_fwd, 32'h2);
    rs2 = 5'd9;
    @(negedge clk);
    check("byp_hit_idle", {31'd0, rs1_hit}, 32'd0);
    check("byp_fwd_idle", rs1_fwd, 32'd0);
    check("byp_hit_miss", {31'd0, rs2_hit}, 32'd0);
    rs1 = 5'd0; rs2 = 5'd0;

    // x0 destination: accepted but never written.
    @(posedge clk); #1;
    send(1'b1, 5'd0, 32'hCAFE);
    @(negedge clk);
    check("x0_count", 32'(count), 32'd0);
    check("x0_enable_a", {31'd0, enable}, 32'd0);
    @(negedge clk);
    check("x0_enable_b", {31'd0, enable}, 32'd0);

    // Reset mid-drain: pending writes discarded immediately, nothing after release.
    @(posedge clk); #1;
    send(1'b0, 5'd10, 32'hA);
    send(1'b0, 5'd11, 32'hB);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rstmid_enable", {31'd0, enable}, 32'd0);
    check("rstmid_count",  32'(count), 32'd0);
    alu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_count_after", 32'(count), 32'd0);
    check("rstmid_enable_after", {31'd0, enable}, 32'd0);

    check("sb_leftover", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
